// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader and the instruction memory.
package imem_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned IMEM_DEPTH = 256;
   localparam int unsigned LEN_W      = 9;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      RUN,
      ERROR
   } loader_state_t;

   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [7:0] idx);
      return base + {22'b0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot link, instruction-memory write port and core-control signals of the boot loader.
interface imem_boot_loader_if;
   import imem_pkg::*;

   logic                start;
   logic [LEN_W-1:0]    len_words;
   logic                byte_valid;
   logic [7:0]          byte_data;
   logic                byte_ready;
   logic                mem_we;
   logic [WORD_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_wdata;
   logic                core_en;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output start, len_words, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, core_en, busy, done, err
   );

   modport slave (
      input  start, len_words, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, core_en, busy, done, err
   );

endinterface

// File: rtl/byte_packer.sv
// Assembles accepted bytes into little-endian words; word/word_valid describe the word completed
// by the byte accepted this cycle.
module byte_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [1:0]  cnt_q;
   logic [23:0] sr_q;

   // Bytes shift in from the top so the first byte lands in bits [7:0] of the final word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else if (clear) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else if (in_valid) begin
         cnt_q <= cnt_q + 2'd1;
         sr_q  <= {in_data, sr_q[23:8]};
      end
   end

   always_comb begin
      word       = {in_data, sr_q};
      word_valid = in_valid && (cnt_q == 2'd3);
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory, then releases the core.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int unsigned       DEPTH     = IMEM_DEPTH,
   parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   imem_boot_loader_if.slave  bus
);

   loader_state_t     state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [7:0]        idx_q;
   logic              last_q, last_d;
   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q;
   logic [WORD_W-1:0] mem_addr_q, mem_wdata_q;

   logic              accept, start_ok, len_over, len_zero;
   logic              data_word, final_word;
   logic [WORD_W-1:0] word;
   logic              word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q;
   logic              chk_done;
   assign chk_done = word_valid && (state_q == CHECK);
`endif

   assign accept     = bus.byte_valid && byte_ready_q;
   assign start_ok   = bus.start && (state_q inside {IDLE, RUN, ERROR});
   assign len_over   = 32'(bus.len_words) > DEPTH;
   assign len_zero   = (bus.len_words == '0);
   // last_q marks that every data word has been assembled; later words are checksum words.
   assign data_word  = word_valid && (state_q == LOAD) && !last_q;
   assign final_word = data_word && ({1'b0, idx_q} == len_q - LEN_W'(1));

   byte_packer u_byte_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .in_valid   (accept),
      .in_data    (bus.byte_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, RUN, ERROR: begin
            if (start_ok) begin
               if (len_over) begin
                  state_d = ERROR;
               end else if (len_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = RUN;
`endif
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = RUN;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (chk_done) begin
               state_d = (word == sum_q) ? RUN : ERROR;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (start_ok) begin
         last_d = 1'b0;
      end else if (final_word) begin
         last_d = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      byte_ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
      byte_ready_d = (state_d == LOAD) && !last_d;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q        <= '0;
         idx_q        <= '0;
         last_q       <= 1'b0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         last_q       <= last_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= data_word;
         if (start_ok) begin
            len_q <= bus.len_words;
            idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q <= '0;
`endif
         end
         if (data_word) begin
            mem_addr_q  <= word_addr(BASE_ADDR, idx_q);
            mem_wdata_q <= word;
            // Holding on the final word keeps idx_q below DEPTH even for a full-depth load.
            if (!final_word) begin
               idx_q <= idx_q + 8'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q <= sum_q + word;
`endif
         end
      end
   end

   always_comb begin
      bus.byte_ready = byte_ready_q;
      bus.mem_we     = mem_we_q;
      bus.mem_addr   = mem_addr_q;
      bus.mem_wdata  = mem_wdata_q;
      bus.core_en    = (state_q == RUN);
      bus.done       = (state_q == RUN);
      bus.err        = (state_q == ERROR);
      bus.busy       = (state_q == LOAD) || (state_q == CHECK);
   end

endmodule
